// File: rtl/spi_master_ctrl.sv
// SPI master feeding spi_wrapper: serialises one {op,payload} request per frame on
// SS_n/MOSI (one bit per clk) and captures the read-data word returned on MISO.
module spi_master_ctrl #(
    parameter int  MEM_DEPTH  = 256,
    parameter int  RD_LATENCY = 2,
    parameter int  GAP_CYCLES = 1,
    localparam int ADDR_SIZE  = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_SIZE-1:0] req_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam int SH_W  = ADDR_SIZE + 2;
    localparam int RX_W  = ADDR_SIZE - 1;
    localparam int CNT_W = $clog2(ADDR_SIZE + 3);

    localparam logic [CNT_W-1:0] TX_LOAD   = CNT_W'(SH_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LATENCY - 2);
    localparam logic [CNT_W-1:0] RX_LOAD   = CNT_W'(ADDR_SIZE - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_CMD,
        ST_TX,
        ST_WAIT,
        ST_RX,
        ST_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic [SH_W-1:0]        shreg_q, shreg_d;
    logic [RX_W-1:0]        rxreg_q, rxreg_d;
    logic [ADDR_SIZE-1:0]   payload;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Shift registers carry no control meaning, so they are left out of reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        rxreg_q <= rxreg_d;
    end

    assign payload = (&req_op) ? {ADDR_SIZE{1'b0}} : req_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        shreg_d     = shreg_q;
        rxreg_d     = rxreg_q;
        SS_n        = 1'b1;
        MOSI        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    shreg_d = {req_op, payload};
                    rd_d    = &req_op;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                SS_n    = 1'b0;
                state_d = ST_CMD;
            end
            // The slave takes its write/read decision from op[1], which is also shreg MSB.
            ST_CMD: begin
                SS_n    = 1'b0;
                MOSI    = shreg_q[SH_W-1];
                cnt_d   = TX_LOAD;
                state_d = ST_TX;
            end
            ST_TX: begin
                SS_n    = 1'b0;
                MOSI    = shreg_q[SH_W-1];
                shreg_d = {shreg_q[SH_W-2:0], 1'b0};
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rd_q) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else if (RD_LATENCY > 1) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d   = RX_LOAD;
                    state_d = ST_RX;
                end
            end
            ST_WAIT: begin
                SS_n = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d   = RX_LOAD;
                    state_d = ST_RX;
                end
            end
            ST_RX: begin
                SS_n    = 1'b0;
                rxreg_d = {rxreg_q[RX_W-2:0], MISO};
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_data_d  = {rxreg_q, MISO};
                    rsp_valid_d = 1'b1;
                    cnt_d       = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = ~req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: two instances (RD_LATENCY 2 and 3), each with a
// behavioural SPI slave that decodes frames and answers rd-data requests on MISO.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid_v = 2'b00;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic [1:0] req_ready_v, busy_v, rsp_valid_v, ss_n_v, mosi_v;
    logic [1:0] miso_v = 2'b00;
    logic [7:0] rsp_data0, rsp_data1;

    int n_cmp = 0;
    int n_fail = 0;

    // slave model state
    int          idx[2]      = '{0, 0};
    logic [31:0] bits[2]     = '{32'd0, 32'd0};
    logic [1:0]  sop[2]      = '{2'b00, 2'b00};
    logic [9:0]  pl[2]       = '{10'd0, 10'd0};
    int          hi_run[2]   = '{0, 0};
    int          min_gap[2]  = '{999, 999};
    int          frames[2]   = '{0, 0};
    int          last_len[2] = '{0, 0};
    logic [31:0] last_bits[2] = '{32'd0, 32'd0};
    int          rsp_cnt[2]  = '{0, 0};
    logic [7:0]  rsp_last[2] = '{8'd0, 8'd0};
    logic [9:0]  flog[16];
    logic [7:0]  mem[256];
    logic [7:0]  wa = 8'd0;
    logic [7:0]  ra = 8'd0;
    bit          miso_fixed = 1'b0;
    bit          min_gap_clr = 1'b0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.MEM_DEPTH(256), .RD_LATENCY(2), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid_v[0]), .rsp_data(rsp_data0),
        .busy(busy_v[0]), .SS_n(ss_n_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0])
    );

    spi_master_ctrl #(.MEM_DEPTH(256), .RD_LATENCY(3), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid_v[1]), .rsp_data(rsp_data1),
        .busy(busy_v[1]), .SS_n(ss_n_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1])
    );

    // Slave: frame bit index 0 = select cycle, 1 = command bit, 2..11 = {op,data}.
    // MISO for rd-data is driven from 11+latency onwards, MSB first.
    always @(negedge clk) begin : slave
        int k;
        logic [7:0] w;
        if (min_gap_clr) begin
            min_gap[0] = 999;
            min_gap_clr = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid_v[d] === 1'b1) begin
                rsp_cnt[d]++;
                rsp_last[d] = (d == 0) ? rsp_data0 : rsp_data1;
            end
            if (ss_n_v[d] === 1'b0) begin
                if (idx[d] == 0 && hi_run[d] < min_gap[d]) min_gap[d] = hi_run[d];
                bits[d] = {bits[d][30:0], mosi_v[d]};
                if (idx[d] == 3) sop[d] = bits[d][1:0];
                if (idx[d] == 11) pl[d] = bits[d][9:0];
                k = idx[d] - 11 - (d + 2);
                if (idx[d] >= 4 && sop[d] == 2'b11 && k >= 0 && k < 8) begin
                    w = (miso_fixed || d == 1) ? 8'hC3 : mem[ra];
                    miso_v[d] = w[7-k];
                end else begin
                    miso_v[d] = 1'b0;
                end
                idx[d]++;
            end else begin
                miso_v[d] = 1'b0;
                if (idx[d] > 0) begin
                    last_len[d]  = idx[d];
                    last_bits[d] = bits[d];
                    if (idx[d] >= 12) begin
                        if (d == 0) begin
                            case (pl[0][9:8])
                                2'b00: wa = pl[0][7:0];
                                2'b01: mem[wa] = pl[0][7:0];
                                2'b10: ra = pl[0][7:0];
                                default: ;
                            endcase
                            if (frames[0] < 16) flog[frames[0]] = pl[0];
                        end
                        frames[d]++;
                    end
                    idx[d]    = 0;
                    bits[d]   = 32'd0;
                    sop[d]    = 2'b00;
                    hi_run[d] = 0;
                end
                hi_run[d]++;
            end
        end
    end

    // Presents one request on instance d and returns the number of busy cycles.
    task automatic send(input int d, input logic [1:0] op, input logic [7:0] data,
                        output int bcyc);
        int n;
        n = 0;
        while (req_ready_v[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_op = op;
        req_data = data;
        req_valid_v[d] = 1'b1;
        @(negedge clk);
        req_valid_v[d] = 1'b0;
        bcyc = 0;
        while (busy_v[d] !== 1'b0 && bcyc < 100) begin
            @(negedge clk);
            bcyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (ss_n_v[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ss_n[%0d]: got %b expected 1", d, ss_n_v[d]);
            end
            n_cmp++;
            if (mosi_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mosi[%0d]: got %b expected 0", d, mosi_v[d]);
            end
            n_cmp++;
            if (req_ready_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready_busy[%0d]: got %b/%b expected 1/0", d,
                         req_ready_v[d], busy_v[d]);
            end
            n_cmp++;
            if (rsp_valid_v[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", d, rsp_valid_v[d]);
            end
        end
        n_cmp++;
        if (rsp_data0 !== 8'h00 || rsp_data1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h/%h expected 00/00", rsp_data0, rsp_data1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wr_addr();
        int bc;
        send(0, 2'b00, 8'hA5, bc);
        n_cmp++;
        if (bc !== 13) begin
            n_fail++;
            $display("FAIL wr_addr_busy_len: got %0d expected 13", bc);
        end
        n_cmp++;
        if (last_len[0] !== 12) begin
            n_fail++;
            $display("FAIL wr_addr_ss_low: got %0d expected 12", last_len[0]);
        end
        n_cmp++;
        if (last_bits[0][11:0] !== 12'h0A5) begin
            n_fail++;
            $display("FAIL wr_addr_mosi_seq: got %b expected 000010100101", last_bits[0][11:0]);
        end
        n_cmp++;
        if (ss_n_v[0] !== 1'b1 || req_ready_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_addr_end: got ss_n=%b ready=%b expected 1/1", ss_n_v[0], req_ready_v[0]);
        end
    endtask

    task automatic test_readback();
        int bc;
        int r0;
        r0 = rsp_cnt[0];
        send(0, 2'b00, 8'h10, bc);
        send(0, 2'b01, 8'h3C, bc);
        n_cmp++;
        if (bc !== 13) begin
            n_fail++;
            $display("FAIL wr_data_busy_len: got %0d expected 13", bc);
        end
        send(0, 2'b10, 8'h10, bc);
        n_cmp++;
        if (rsp_cnt[0] !== r0) begin
            n_fail++;
            $display("FAIL rb_no_rsp_on_writes: got %0d pulses expected 0", rsp_cnt[0] - r0);
        end
        send(0, 2'b11, 8'hFF, bc);
        n_cmp++;
        if (bc !== 22) begin
            n_fail++;
            $display("FAIL rd_data_busy_len: got %0d expected 22", bc);
        end
        n_cmp++;
        if (pl[0] !== 10'h300) begin
            n_fail++;
            $display("FAIL rd_data_payload_zero: got %h expected 300", pl[0]);
        end
        n_cmp++;
        if (rsp_cnt[0] - r0 !== 1) begin
            n_fail++;
            $display("FAIL rb_rsp_pulses: got %0d expected 1", rsp_cnt[0] - r0);
        end
        n_cmp++;
        if (rsp_last[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL rb_rsp_data: got %h expected 3c", rsp_last[0]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_data0 !== 8'h3C || rsp_valid_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_rsp_hold: got %h valid=%b expected 3c valid=0", rsp_data0, rsp_valid_v[0]);
        end
    endtask

    task automatic test_rd_latency();
        int bc;
        int r1;
        miso_fixed = 1'b1;
        send(0, 2'b11, 8'h00, bc);
        n_cmp++;
        if (bc !== 22 || rsp_last[0] !== 8'hC3) begin
            n_fail++;
            $display("FAIL lat2_rd: got len=%0d data=%h expected 22/c3", bc, rsp_last[0]);
        end
        r1 = rsp_cnt[1];
        send(1, 2'b11, 8'h00, bc);
        n_cmp++;
        if (bc !== 23) begin
            n_fail++;
            $display("FAIL lat3_len: got %0d expected 23", bc);
        end
        n_cmp++;
        if (rsp_last[1] !== 8'hC3 || rsp_cnt[1] - r1 !== 1) begin
            n_fail++;
            $display("FAIL lat3_rsp: got %h x%0d expected c3 x1", rsp_last[1], rsp_cnt[1] - r1);
        end
        miso_fixed = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bc;
        int f0;
        int r0;
        f0 = frames[0];
        r0 = rsp_cnt[0];
        req_op = 2'b01;
        req_data = 8'h5A;
        req_valid_v[0] = 1'b1;
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        repeat (7) @(negedge clk);
        // TX bit 5 of {01,5A} is 1
        n_cmp++;
        if (ss_n_v[0] !== 1'b0 || mosi_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_bit5: got ss_n=%b mosi=%b expected 0/1", ss_n_v[0], mosi_v[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ss_n_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || mosi_v[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ss_n=%b busy=%b mosi=%b expected 1/0/0",
                     ss_n_v[0], busy_v[0], mosi_v[0]);
        end
        n_cmp++;
        if (rsp_data0 !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_rsp_clear: got %h expected 00", rsp_data0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rsp_cnt[0] !== r0 || frames[0] !== f0) begin
            n_fail++;
            $display("FAIL abort_no_rsp: got rsp=%0d frames=%0d expected %0d/%0d",
                     rsp_cnt[0], frames[0], r0, f0);
        end
        send(0, 2'b01, 8'h5A, bc);
        n_cmp++;
        if (bc !== 13 || last_len[0] !== 12) begin
            n_fail++;
            $display("FAIL after_abort_len: got busy=%0d low=%0d expected 13/12", bc, last_len[0]);
        end
        n_cmp++;
        if (last_bits[0][11:0] !== 12'h15A) begin
            n_fail++;
            $display("FAIL after_abort_seq: got %h expected 15a", last_bits[0][11:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops[4];
        logic [7:0] dat[4];
        logic [9:0] expv;
        int f0;
        int r0;
        int n;
        ops = '{2'b00, 2'b01, 2'b10, 2'b11};
        dat = '{8'h20, 8'h77, 8'h20, 8'hEE};
        f0 = frames[0];
        r0 = rsp_cnt[0];
        min_gap_clr = 1'b1;
        req_valid_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_op = ops[i];
            req_data = dat[i];
            n = 0;
            while (req_ready_v[0] !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (n >= 200) begin
                n_fail++;
                $display("FAIL b2b_accept_timeout[%0d]: got no req_ready expected accept", i);
            end
            @(negedge clk);
        end
        req_valid_v[0] = 1'b0;
        n = 0;
        while (busy_v[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (frames[0] - f0 !== 4) begin
            n_fail++;
            $display("FAIL b2b_frame_count: got %0d expected 4", frames[0] - f0);
        end
        for (int i = 0; i < 4; i++) begin
            expv = (ops[i] == 2'b11) ? {ops[i], 8'h00} : {ops[i], dat[i]};
            n_cmp++;
            if (flog[f0+i] !== expv) begin
                n_fail++;
                $display("FAIL b2b_frame[%0d]: got %h expected %h", i, flog[f0+i], expv);
            end
        end
        n_cmp++;
        if (min_gap[0] < 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d expected >=1", min_gap[0]);
        end
        n_cmp++;
        if (rsp_cnt[0] - r0 !== 1 || rsp_last[0] !== 8'h77) begin
            n_fail++;
            $display("FAIL b2b_rsp: got %h x%0d expected 77 x1", rsp_last[0], rsp_cnt[0] - r0);
        end
    endtask

    initial begin
        test_reset();
        test_wr_addr();
        test_readback();
        test_rd_latency();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
